// File: rtl/usb_slv_pkg.sv
// Shared definitions for the AXI USB slave response path.
//   rsp_state_e        : response encoder FSM states
//   USB_MEM_SEL_BIT    : address bit selecting register file (1) vs packet memory (0)
//   USB_ADDR_MSB_VALID : highest address bit inside the decoded window
//   LAT_MIN / LAT_MAX  : legal range of store read latencies
package usb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rsp_state_e;

  localparam int unsigned USB_MEM_SEL_BIT    = 10;
  localparam int unsigned USB_ADDR_MSB_VALID = 10;
  localparam int unsigned LAT_MIN            = 1;
  localparam int unsigned LAT_MAX            = 4;

endpackage

// File: rtl/usb_slv_rsp_encoder_if.sv
// Bus-side and store-side signal bundle of the response encoder.
//   req_*  : request from the address decoder (valid/ready handshake)
//   *_rdata: read data from packet memory port B and register file
//   rsp_*  : registered response toward the bus slave (valid/ready handshake)
// Modport slave is the encoder; master is the surrounding bus/store logic.
interface usb_slv_rsp_encoder_if #(
  parameter int unsigned DW = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [31:0]   req_addr_i;
  logic [DW-1:0] mem_rdata_i;
  logic [DW-1:0] reg_rdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_write_o;
  logic          rsp_err_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, mem_rdata_i, reg_rdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_write_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, mem_rdata_i, reg_rdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_write_o, rsp_err_o
  );
endinterface

// File: rtl/usb_slv_rsp_encoder.sv
// Response-side encoder for the AXI USB slave.
// Accepts one request at a time, waits the fixed read latency of the targeted
// store (packet memory or register file), captures the read word and holds a
// registered response until the bus side accepts it.
// Ports:
//   Clk : clock, all state on rising edge
//   Rst : synchronous active-high reset
//   bus : usb_slv_rsp_encoder_if.slave (request, store read data, response)
// Parameters: MEM_LAT / REG_LAT (1..4) store read latencies, DW data width.
module usb_slv_rsp_encoder
  import usb_slv_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned REG_LAT = 1,
  parameter int unsigned DW      = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  usb_slv_rsp_encoder_if.slave   bus
);

  if (MEM_LAT < LAT_MIN || MEM_LAT > LAT_MAX) begin : g_bad_mem_lat
    $fatal(1, "usb_slv_rsp_encoder: MEM_LAT out of range 1..4");
  end
  if (REG_LAT < LAT_MIN || REG_LAT > LAT_MAX) begin : g_bad_reg_lat
    $fatal(1, "usb_slv_rsp_encoder: REG_LAT out of range 1..4");
  end

  // Counter preload: WAIT is entered after the accept edge, so LAT-1 more edges.
  localparam logic [1:0] MEM_CNT = 2'(MEM_LAT - 1);
  localparam logic [1:0] REG_CNT = 2'(REG_LAT - 1);

  rsp_state_e    state, state_n;
  logic [1:0]    lat_cnt, lat_cnt_n;
  logic          sel_reg, sel_reg_n;
  logic [DW-1:0] data_q, data_n;
  logic          write_q, write_n;
  logic          err_q, err_n;

  logic          ready;
  logic          accept;
  logic          req_sel_reg;
  logic          req_err;

  assign req_sel_reg = bus.req_addr_i[USB_MEM_SEL_BIT];
  assign req_err     = |bus.req_addr_i[31:USB_ADDR_MSB_VALID+1];

  // Ready is masked during the reset cycle so nothing is accepted while Rst is high.
  assign ready  = (state == IDLE) && !Rst;
  assign accept = bus.req_valid_i && ready;

  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    sel_reg_n = sel_reg;
    data_n    = data_q;
    write_n   = write_q;
    err_n     = err_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sel_reg_n = req_sel_reg;
          write_n   = bus.req_write_i;
          err_n     = req_err;
          if (req_err || bus.req_write_i) begin
            data_n  = '0;
            state_n = RESP;
          end else begin
            lat_cnt_n = req_sel_reg ? REG_CNT : MEM_CNT;
            state_n   = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt == 2'd0) begin
          data_n  = sel_reg ? bus.reg_rdata_i : bus.mem_rdata_i;
          state_n = RESP;
        end else begin
          lat_cnt_n = lat_cnt - 2'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      sel_reg <= 1'b0;
      data_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
      sel_reg <= sel_reg_n;
      data_q  <= data_n;
      write_q <= write_n;
      err_q   <= err_n;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_write_o = write_q;
  assign bus.rsp_err_o   = err_q;

endmodule

// File: doc/usb_slv_rsp_encoder.md
# usb_slv_rsp_encoder

Response-side encoder for the AXI USB slave. It takes each bus request that the address decoder has accepted, waits the fixed read latency of the targeted store (packet memory port B or the register file), and captures the returned word. It then presents a single registered response to the bus-side interface and holds it until that side accepts it. It is the return-path counterpart of the address decoder and sits between the memory/register-file read ports and the bus slave response channel.

## Interface
Parameters:
- MEM_LAT, default 1: cycles from memory address issue to valid `mem_rdata_i` (range 1–4).
- REG_LAT, default 1: cycles from register address issue to valid `reg_rdata_i` (range 1–4).
- DW, default 32: data width.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request pending.
- req_ready_o  out  1  encoder can accept a request.
- req_write_i  in  1  1 = write (bus to USB), 0 = read (USB to bus).
- req_addr_i  in  32  byte address of the request.
- mem_rdata_i  in  DW  packet memory port B read data.
- reg_rdata_i  in  DW  register file read data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  DW  read data; 0 for writes and errors.
- rsp_write_o  out  1  response belongs to a write.
- rsp_err_o  out  1  address outside the decoded window.

## Operation
- Request handshake: a request is taken when req_valid_i && req_ready_o at a rising edge. `req_addr_i` and `req_write_i` are captured on that edge.
- Target selection:
  - `sel_reg` = addr[10].
  - `err` = |addr[31:11].
- State machine, states IDLE, WAIT, RESP:
  - IDLE: req_ready_o = 1.
    - On accept with `err`, or on accept of a write: go to RESP. rsp_data_o = 0, rsp_err_o = err, rsp_write_o = write.
    - On accept of a valid read: load `lat_cnt` = (sel_reg ? REG_LAT : MEM_LAT) − 1 and go to WAIT.
  - WAIT: req_ready_o = 0.
    - If `lat_cnt` == 0: capture sel_reg ? reg_rdata_i : mem_rdata_i into rsp_data_o and go to RESP.
    - Otherwise decrement `lat_cnt`.
  - RESP: rsp_valid_o = 1 and all response fields held stable. On rsp_ready_i, go to IDLE.
- No request is accepted while WAIT or RESP is occupied; there is no outstanding-transaction overlap.
- rsp_err_o and rsp_write_o may both be 1 (errored write).
- `lat_cnt` is 2 bits wide. Parameter values outside 1–4 are illegal and are flagged by an elaboration-time assertion.

## Timing
- Reset values:
  - req_ready_o = 0 during the reset cycle, 1 from the first cycle after reset.
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_write_o = 0, rsp_err_o = 0.
  - State = IDLE, `lat_cnt` = 0.
- Read accepted at edge T: read data is sampled at edge T+LAT, and rsp_valid_o is high from T+LAT until the accepting edge.
- Write or error accepted at edge T: rsp_valid_o is high after edge T (one-cycle response).
- Response accepted at edge A: rsp_valid_o = 0 and req_ready_o = 1 after A. The next request can be accepted at A+1.
  - Peak read throughput: one per LAT+2 cycles.
  - Peak write throughput: one per 2 cycles.
- rsp_ready_i high while rsp_valid_o is low has no effect.
- rsp_data_o is registered and changes only on entry to RESP or on reset.
- Reset asserted mid-WAIT or mid-RESP: the pending transaction is discarded with no response. The outputs reach their reset values at the reset edge.

## Structure
- Shared package `usb_slv_pkg`:
  - State enum `rsp_state_e` {IDLE, WAIT, RESP}.
  - `USB_MEM_SEL_BIT` = 10.
  - `USB_ADDR_MSB_VALID` = 10.
  - Latency bounds LAT_MIN = 1, LAT_MAX = 4.
- No sub-module. The latency counter and the data mux stay inline.

## Test plan
- Memory read, MEM_LAT = 1: addr 0x0000_0010, mem_rdata_i = 0xDEAD_BEEF one cycle after accept, rsp_ready_i held 1 → rsp_valid_o for exactly one cycle with rsp_data_o = 0xDEAD_BEEF, rsp_err_o = 0, rsp_write_o = 0.
- Register read, REG_LAT = 2: addr 0x0000_0404, reg_rdata_i = 0x0000_00A5 two cycles after accept → rsp_valid_o rises 2 cycles after accept with data 0xA5; req_ready_o = 0 throughout.
- Write: addr 0x0000_0008, write = 1 → rsp_valid_o one cycle after accept, rsp_write_o = 1, rsp_data_o = 0, rsp_err_o = 0.
- Out-of-window read: addr 0x0000_1000 → rsp_err_o = 1, rsp_data_o = 0, no wait on memory.
- Backpressure: rsp_ready_i held 0 for 5 cycles during RESP while req_valid_i = 1 and mem_rdata_i toggles → response stable, req_ready_o = 0, no second accept until one cycle after rsp_ready_i = 1.
- Reset in WAIT: assert Rst one cycle after a read is accepted → all outputs 0, no rsp_valid_o afterwards; the next read after reset completes normally.
